// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel output stage.
// Holds the writer FSM encodings, the default lane geometry and the frame-size helpers.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int SOBEL_DWIDTH   = 8;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int PACK           = WORD_WIDTH_DEF / SOBEL_DWIDTH;
  localparam int LANE_W         = (PACK > 1) ? $clog2(PACK) : 1;

  function automatic logic [31:0] total_pixels(input int width, input int height);
    return 32'(width * height);
  endfunction

  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/pixel_word_packer.sv
// Packs pixels little-endian into words and holds each finished word until the word FIFO accepts it.
// A flush pads the unused upper lanes of a partial word and releases it as a normal word.
module pixel_word_packer
  import sobel_pkg::*;
#(
  parameter int                   DWIDTH_IN  = SOBEL_DWIDTH,
  parameter int                   WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int                   LANES      = PACK,
  parameter int                   LANE_BITS  = LANE_W,
  parameter logic [DWIDTH_IN-1:0] PAD_VALUE  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  out_full,
  input  logic [DWIDTH_IN-1:0]  pixel,
  output logic                  partial,
  output logic                  word_valid,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] word
);

  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

  logic [LANE_BITS-1:0]  lane_q, lane_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] merged;

  assign wr_en      = valid_q & ~out_full;
  assign word_valid = valid_q;
  assign word       = word_q;
  assign partial    = (lane_q != '0);

  // A word completing on the same cycle as a write keeps valid set, so back-to-back words never stall.
  always_comb begin
    merged  = acc_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = valid_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_BITS'(i)) merged[i*DWIDTH_IN +: DWIDTH_IN] = pixel;
    end
    if (wr_en) valid_d = 1'b0;
    if (clear) begin
      lane_d  = '0;
      acc_d   = '0;
      valid_d = 1'b0;
    end else if (pop) begin
      if (lane_q == LAST_LANE) begin
        word_d  = merged;
        valid_d = 1'b1;
        lane_d  = '0;
        acc_d   = '0;
      end else begin
        acc_d  = merged;
        lane_d = lane_q + LANE_BITS'(1);
      end
    end else if (flush) begin
      word_d = acc_q;
      for (int i = 0; i < LANES; i++) begin
        if (i >= int'(lane_q)) word_d[i*DWIDTH_IN +: DWIDTH_IN] = PAD_VALUE;
      end
      valid_d = 1'b1;
      lane_d  = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q  <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/sobel_frame_writer.sv
// Drains the sobel pixel FIFO for exactly one frame per start pulse and pushes packed words downstream.
// The FSM and pixel counter live here; lane packing and word hand-off live in pixel_word_packer.
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int                   IMG_WIDTH  = 720,
  parameter int                   IMG_HEIGHT = 540,
  parameter int                   DWIDTH_IN  = SOBEL_DWIDTH,
  parameter int                   WORD_WIDTH = WORD_WIDTH_DEF,
  parameter logic [DWIDTH_IN-1:0] PAD_VALUE  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [WORD_WIDTH-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pixel_count
);

  localparam int          LANES     = WORD_WIDTH / DWIDTH_IN;
  localparam int          LANE_BITS = lane_bits(LANES);
  localparam logic [31:0] TOTAL     = total_pixels(IMG_WIDTH, IMG_HEIGHT);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] count_q, count_d;
  logic        word_valid;
  logic        partial;
  logic        accept;
  logic        flush;

  assign accept = (state_q == ST_IDLE) & start;

  // A pop is allowed only when the word slot is free or is being emptied this very cycle.
  assign fifo_in_rd_en = (state_q == ST_RUN) & ~fifo_in_empty & (count_q < TOTAL)
                         & (~word_valid | fifo_out_wr_en);
  assign flush = (state_q == ST_FLUSH) & (~word_valid | fifo_out_wr_en);

  pixel_word_packer #(
    .DWIDTH_IN (DWIDTH_IN),
    .WORD_WIDTH(WORD_WIDTH),
    .LANES     (LANES),
    .LANE_BITS (LANE_BITS),
    .PAD_VALUE (PAD_VALUE)
  ) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (accept),
    .pop       (fifo_in_rd_en),
    .flush     (flush),
    .out_full  (fifo_out_full),
    .pixel     (fifo_in_dout),
    .partial   (partial),
    .word_valid(word_valid),
    .wr_en     (fifo_out_wr_en),
    .word      (fifo_out_din)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (fifo_in_rd_en) count_d = count_q + 32'd1;
        if (count_q == TOTAL) state_d = partial ? ST_FLUSH : ST_DRAIN;
      end
      ST_FLUSH: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!word_valid) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_count = count_q;

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed bench for sobel_frame_writer: a 4x2 instance driven from a vector table plus corner sequences,
// and a 3x1 instance for the padded final word.
module tb_sobel_frame_writer;

  logic        clock = 1'b0;
  logic        reset;

  logic        start_a, rd_en_a, empty_a, wr_en_a, full_a, busy_a, done_a;
  logic [7:0]  dout_a;
  logic [31:0] din_a, count_a;

  logic        start_b, rd_en_b, empty_b, wr_en_b, full_b, busy_b, done_b;
  logic [7:0]  dout_b;
  logic [31:0] din_b, count_b;

  logic [7:0]  in_a[$];
  logic [7:0]  in_b[$];
  logic [31:0] out_a[$];
  logic [31:0] out_b[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  int done_cnt_a   = 0;
  int done_cnt_b   = 0;
  int rd_viol_a    = 0;
  int wr_cycle_b   = 0;
  int done_cycle_b = 0;

  typedef struct {
    string       name;
    logic [63:0] pix;
    int          gap;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[3];

  always #5 clock = ~clock;

  sobel_frame_writer #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .DWIDTH_IN(8), .WORD_WIDTH(32), .PAD_VALUE(8'h00)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .fifo_in_rd_en(rd_en_a), .fifo_in_dout(dout_a), .fifo_in_empty(empty_a),
    .fifo_out_wr_en(wr_en_a), .fifo_out_din(din_a), .fifo_out_full(full_a),
    .busy(busy_a), .done(done_a), .pixel_count(count_a)
  );

  sobel_frame_writer #(
    .IMG_WIDTH(3), .IMG_HEIGHT(1), .DWIDTH_IN(8), .WORD_WIDTH(32), .PAD_VALUE(8'h00)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .fifo_in_rd_en(rd_en_b), .fifo_in_dout(dout_b), .fifo_in_empty(empty_b),
    .fifo_out_wr_en(wr_en_b), .fifo_out_din(din_b), .fifo_out_full(full_b),
    .busy(busy_b), .done(done_b), .pixel_count(count_b)
  );

  // FWFT view of the input queues.
  task automatic refresh();
    empty_a = (in_a.size() == 0);
    dout_a  = empty_a ? 8'h00 : in_a[0];
    empty_b = (in_b.size() == 0);
    dout_b  = empty_b ? 8'h00 : in_b[0];
  endtask

  // One clock: FIFO models act on the values present at the edge, then inputs settle 1 time unit later.
  task automatic tick();
    refresh();
    @(posedge clock);
    cycle++;
    if (rd_en_a) begin
      if (empty_a) rd_viol_a++;
      if (in_a.size() > 0) void'(in_a.pop_front());
    end
    if (wr_en_a && !full_a) out_a.push_back(din_a);
    if (done_a) done_cnt_a++;
    if (rd_en_b && in_b.size() > 0) void'(in_b.pop_front());
    if (wr_en_b && !full_b) begin
      out_b.push_back(din_b);
      wr_cycle_b = cycle;
    end
    if (done_b) begin
      done_cnt_b++;
      done_cycle_b = cycle;
    end
    #1;
    refresh();
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame_a();
    out_a.delete();
    done_cnt_a = 0;
    rd_viol_a  = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int k;
    k = 0;
    while (done_cnt_a == 0 && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check_output({name, " done_pulses"}, 64'(done_cnt_a), 64'd1);
  endtask

  task automatic check_frame_a(input string name, input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] got0, got1;
    got0 = 'x;
    got1 = 'x;
    if (out_a.size() > 0) got0 = 64'(out_a[0]);
    if (out_a.size() > 1) got1 = 64'(out_a[1]);
    check_output({name, " nwords"}, 64'(out_a.size()), 64'd2);
    check_output({name, " word0"}, got0, 64'(w0));
    check_output({name, " word1"}, got1, 64'(w1));
    check_output({name, " pixel_count"}, 64'(count_a), 64'd8);
    check_output({name, " busy_after"}, 64'(busy_a), 64'd0);
    check_output({name, " rd_while_empty"}, 64'(rd_viol_a), 64'd0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    int k;
    if (v.gap == 0)
      for (int i = 0; i < 8; i++) in_a.push_back(v.pix[i*8 +: 8]);
    start_frame_a();
    if (v.gap != 0) begin
      for (int i = 0; i < 8; i++) begin
        in_a.push_back(v.pix[i*8 +: 8]);
        k = 0;
        while (in_a.size() != 0 && k < 20) begin
          tick();
          k++;
        end
        repeat (v.gap) tick();
      end
    end
    wait_done_a(v.name);
    check_frame_a(v.name, v.w0, v.w1);
  endtask

  initial begin
    int k;
    logic [31:0] held;
    logic        stable;

    vecs[0] = '{"seq",   64'h0807060504030201, 0, 32'h04030201, 32'h08070605};
    vecs[1] = '{"gaps",  64'h0807060504030201, 3, 32'h04030201, 32'h08070605};
    vecs[2] = '{"mixed", 64'h55AA00FF10203040, 1, 32'h10203040, 32'h55AA00FF};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; full_a = 1'b0; full_b = 1'b0;
    refresh();
    repeat (3) tick();
    check_output("rst busy", 64'(busy_a), 64'd0);
    check_output("rst done", 64'(done_a), 64'd0);
    reset = 1'b0;
    tick();
    check_output("idle rd_en", 64'(rd_en_a), 64'd0);
    check_output("idle wr_en", 64'(wr_en_a), 64'd0);
    check_output("idle din", 64'(din_a), 64'd0);
    check_output("idle pixel_count", 64'(count_a), 64'd0);

    for (int i = 0; i < 3; i++) apply_stimulus(vecs[i]);

    // 3x1 frame: partial word padded, done after its write
    for (int i = 1; i <= 3; i++) in_b.push_back(8'(i));
    out_b.delete();
    done_cnt_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    k = 0;
    while (done_cnt_b == 0 && k < 100) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check_output("pad nwords", 64'(out_b.size()), 64'd1);
    check_output("pad word", (out_b.size() > 0) ? 64'(out_b[0]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'h00030201);
    check_output("pad pixel_count", 64'(count_b), 64'd3);
    check_output("pad done_pulses", 64'(done_cnt_b), 64'd1);
    check_output("pad done_after_write", 64'(done_cycle_b > wr_cycle_b), 64'd1);

    // Backpressure: word held, pops stop, start while busy ignored
    for (int i = 1; i <= 8; i++) in_a.push_back(8'(i));
    full_a = 1'b1;
    start_frame_a();
    repeat (8) tick();
    check_output("bp popped_left", 64'(in_a.size()), 64'd4);
    check_output("bp wr_en", 64'(wr_en_a), 64'd0);
    check_output("bp rd_en", 64'(rd_en_a), 64'd0);
    check_output("bp din", 64'(din_a), 64'h04030201);
    held = din_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (din_a !== held || wr_en_a !== 1'b0 || rd_en_a !== 1'b0) stable = 1'b0;
    end
    check_output("bp held_stable", 64'(stable), 64'd1);
    check_output("bp busy_start_ignored", 64'(busy_a), 64'd1);
    check_output("bp count_start_ignored", 64'(count_a), 64'd4);
    full_a = 1'b0;
    wait_done_a("bp");
    check_frame_a("bp", 32'h04030201, 32'h08070605);

    // Excess input stays queued for the next frame
    for (int i = 1; i <= 10; i++) in_a.push_back(8'(i));
    start_frame_a();
    wait_done_a("excess");
    check_frame_a("excess", 32'h04030201, 32'h08070605);
    check_output("excess left", 64'(in_a.size()), 64'd2);
    for (int i = 11; i <= 16; i++) in_a.push_back(8'(i));
    start_frame_a();
    wait_done_a("excess2");
    check_frame_a("excess2", 32'h0C0B0A09, 32'h100F0E0D);

    // Reset mid-frame discards the partial word
    for (int i = 8'h11; i <= 8'h18; i++) in_a.push_back(8'(i));
    start_frame_a();
    k = 0;
    while (in_a.size() > 3 && k < 20) begin
      tick();
      k++;
    end
    reset = 1'b1;
    tick();
    check_output("midrst busy", 64'(busy_a), 64'd0);
    check_output("midrst done", 64'(done_a), 64'd0);
    check_output("midrst rd_en", 64'(rd_en_a), 64'd0);
    tick();
    reset = 1'b0;
    in_a.delete();
    out_a.delete();
    tick();
    for (int i = 8'h21; i <= 8'h28; i++) in_a.push_back(8'(i));
    start_frame_a();
    wait_done_a("after_rst");
    check_frame_a("after_rst", 32'h24232221, 32'h28272625);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
